// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction encoder with immediate range checks and sequential word addressing
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [1:0]  out_err_code
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [2:0]  FMT_R = 3'd0;
    localparam logic [2:0]  FMT_I = 3'd1;
    localparam logic [2:0]  FMT_S = 3'd2;
    localparam logic [2:0]  FMT_B = 3'd3;
    localparam logic [2:0]  FMT_U = 3'd4;
    localparam logic [2:0]  FMT_J = 3'd5;

    localparam logic [1:0]  ERR_NONE  = 2'd0;
    localparam logic [1:0]  ERR_RANGE = 2'd1;
    localparam logic [1:0]  ERR_ALIGN = 2'd2;
    localparam logic [1:0]  ERR_FMT   = 2'd3;

    // Rejected requests still emit a harmless instruction (addi x0,x0,0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (MEM_WORDS - 1));

    state_t      state_q, state_d;

    logic [2:0]  fmt_q;
    logic [6:0]  opcode_q;
    logic [4:0]  rd_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [2:0]  funct3_q;
    logic [6:0]  funct7_q;
    logic [31:0] imm_q;

    logic [31:0] instr_q, instr_d;
    logic [31:0] addr_q;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;
    logic [31:0] raw_instr;

    logic        accept;
    logic        out_hs;
    logic        fits_12;
    logic        fits_13;
    logic        fits_21;

    // Ready is also gated by reset so the encoder never accepts while being reset.
    assign in_ready     = (state_q == IDLE) && !reset;
    assign out_valid    = (state_q == HOLD);
    assign accept       = in_valid && in_ready;
    assign out_hs       = out_valid && out_ready;

    assign out_instr    = instr_q;
    assign out_addr     = addr_q;
    assign out_err      = err_q;
    assign out_err_code = code_q;

    // A value fits an N-bit signed field when every bit above the sign bit copies it.
    assign fits_12 = (&imm_q[31:11]) || !(|imm_q[31:11]);
    assign fits_13 = (&imm_q[31:12]) || !(|imm_q[31:12]);
    assign fits_21 = (&imm_q[31:20]) || !(|imm_q[31:20]);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one cycle to encode, then hold until the consumer takes it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ENC;
            ENC:     state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the request fields at acceptance; they are ignored in every other state.
    always_ff @(posedge clk) begin
        if (reset) begin
            fmt_q    <= 3'd0;
            opcode_q <= 7'd0;
            rd_q     <= 5'd0;
            rs1_q    <= 5'd0;
            rs2_q    <= 5'd0;
            funct3_q <= 3'd0;
            funct7_q <= 7'd0;
            imm_q    <= 32'd0;
        end else if (accept) begin
            fmt_q    <= in_fmt;
            opcode_q <= in_opcode;
            rd_q     <= in_rd;
            rs1_q    <= in_rs1;
            rs2_q    <= in_rs2;
            funct3_q <= in_funct3;
            funct7_q <= in_funct7;
            imm_q    <= in_imm;
        end
    end

    // Error classification: illegal format beats alignment, which beats range.
    always_comb begin
        code_d = ERR_NONE;
        if (fmt_q > FMT_J) begin
            code_d = ERR_FMT;
        end else if ((fmt_q == FMT_B || fmt_q == FMT_J) && imm_q[0]) begin
            code_d = ERR_ALIGN;
        end else if ((fmt_q == FMT_I || fmt_q == FMT_S) && !fits_12) begin
            code_d = ERR_RANGE;
        end else if (fmt_q == FMT_B && !fits_13) begin
            code_d = ERR_RANGE;
        end else if (fmt_q == FMT_J && !fits_21) begin
            code_d = ERR_RANGE;
        end else if (fmt_q == FMT_U && (imm_q[11:0] != 12'd0)) begin
            code_d = ERR_RANGE;
        end
        err_d = (code_d != ERR_NONE);
    end

    // Scatter the immediate into the instruction word for each format.
    always_comb begin
        raw_instr = NOP_INSTR;
        unique case (fmt_q)
            FMT_R: raw_instr = {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, opcode_q};
            FMT_I: raw_instr = {imm_q[11:0], rs1_q, funct3_q, rd_q, opcode_q};
            FMT_S: raw_instr = {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], opcode_q};
            FMT_B: raw_instr = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct3_q,
                                imm_q[4:1], imm_q[11], opcode_q};
            FMT_U: raw_instr = {imm_q[31:12], rd_q, opcode_q};
            FMT_J: raw_instr = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, opcode_q};
            default: raw_instr = NOP_INSTR;
        endcase
        instr_d = err_d ? NOP_INSTR : raw_instr;
    end

    // Result registers load once in ENC and stay frozen through HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= 32'd0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else if (state_q == ENC) begin
            instr_q <= instr_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    // Address counter: moves only when a good result is handed off, wrapping at memory end.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= BASE_ADDR;
        end else if (out_hs && !err_q) begin
            addr_q <= (addr_q == LAST_ADDR) ? BASE_ADDR : addr_q + 32'd4;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized self-checking bench for instr_encoder against a reference model
module tb_instr_encoder;

    localparam logic [31:0] BASE    = 32'h0000_0000;
    localparam int          WORDS_A = 256;
    localparam int          WORDS_B = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_err;
    logic [31:0] a_out_instr, a_out_addr;
    logic [1:0]  a_out_err_code;
    logic        b_in_ready, b_out_valid, b_out_err;
    logic [31:0] b_out_instr, b_out_addr;
    logic [1:0]  b_out_err_code;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_a, exp_b;

    always #5 clk = ~clk;

    instr_encoder #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS_A)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_instr(a_out_instr),
        .out_addr(a_out_addr), .out_err(a_out_err), .out_err_code(a_out_err_code)
    );

    instr_encoder #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS_B)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_instr(b_out_instr),
        .out_addr(b_out_addr), .out_err(b_out_err), .out_err_code(b_out_err_code)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
        logic [31:0] mask;
        mask = (hi - lo == 31) ? 32'hFFFF_FFFF : ((32'd1 << (hi - lo + 1)) - 32'd1);
        return (v >> lo) & mask;
    endfunction

    // Reference: classify by signed numeric range, then place fields by shifting.
    function automatic void ref_encode(input int fmt, input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [2:0] f3, input logic [6:0] f7,
                                       input logic [31:0] imm,
                                       output logic [31:0] instr, output logic [1:0] code);
        int si;
        logic [31:0] base;
        si = $signed(imm);
        code = 2'd0;
        if (fmt > 5) code = 2'd3;
        else if ((fmt == 3 || fmt == 5) && (imm % 2 != 0)) code = 2'd2;
        else if ((fmt == 1 || fmt == 2) && (si < -2048 || si > 2047)) code = 2'd1;
        else if (fmt == 3 && (si < -4096 || si > 4095)) code = 2'd1;
        else if (fmt == 5 && (si < -(1 << 20) || si > (1 << 20) - 1)) code = 2'd1;
        else if (fmt == 4 && (imm % 4096 != 0)) code = 2'd1;
        base = (32'(f3) << 12) | 32'(op);
        case (fmt)
            0: instr = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | base | (32'(rd) << 7);
            1: instr = (fld(imm, 11, 0) << 20) | (32'(rs1) << 15) | base | (32'(rd) << 7);
            2: instr = (fld(imm, 11, 5) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | base
                       | (fld(imm, 4, 0) << 7);
            3: instr = (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | (32'(rs2) << 20)
                       | (32'(rs1) << 15) | base | (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7);
            4: instr = (fld(imm, 31, 12) << 12) | (32'(rd) << 7) | 32'(op);
            5: instr = (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20)
                       | (fld(imm, 19, 12) << 12) | (32'(rd) << 7) | 32'(op);
            default: instr = 32'h13;
        endcase
        if (code != 2'd0) instr = 32'h0000_0013;
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input int words);
        return BASE + ((a - BASE + 32'd4) % (32'(words) * 32'd4));
    endfunction

    task automatic scramble_inputs();
        in_fmt    = 3'($urandom);
        in_opcode = 7'($urandom);
        in_rd     = 5'($urandom);
        in_rs1    = 5'($urandom);
        in_rs2    = 5'($urandom);
        in_funct3 = 3'($urandom);
        in_funct7 = 7'($urandom);
        in_imm    = $urandom;
    endtask

    // One request through both encoders; optionally stalls in HOLD and optionally releases.
    task automatic send(input int fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm,
                        input int hold, input bit release_it,
                        output logic [31:0] got_instr, output logic [1:0] got_code,
                        output logic [31:0] got_addr_b);
        logic [31:0] e_instr;
        logic [1:0]  e_code;
        int budget;
        ref_encode(fmt, op, rd, rs1, rs2, f3, f7, imm, e_instr, e_code);
        budget = 0;
        while (!a_in_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("in_ready_wait", {a_in_ready, b_in_ready}, 2'b11);
        in_valid  = 1'b1;
        in_fmt    = 3'(fmt);
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        @(negedge clk);
        in_valid = 1'b0;
        scramble_inputs();
        check("enc_cycle_valid", {a_out_valid, b_out_valid, a_in_ready}, 3'b000);
        @(negedge clk);
        check("latency_valid", {a_out_valid, b_out_valid}, 2'b11);
        check("instr_a", a_out_instr, e_instr);
        check("instr_b", b_out_instr, e_instr);
        check("err_a", {a_out_err, a_out_err_code}, {e_code != 2'd0, e_code});
        check("err_b", {b_out_err, b_out_err_code}, {e_code != 2'd0, e_code});
        check("addr_a", a_out_addr, exp_a);
        check("addr_b", b_out_addr, exp_b);
        got_instr  = a_out_instr;
        got_code   = a_out_err_code;
        got_addr_b = b_out_addr;
        for (int k = 0; k < hold; k++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            scramble_inputs();
            @(negedge clk);
            check("hold_state", {a_out_valid, a_in_ready, b_out_valid, b_in_ready}, 4'b1010);
            check("hold_instr", a_out_instr, e_instr);
            check("hold_addr", a_out_addr, exp_a);
            check("hold_code", a_out_err_code, e_code);
        end
        if (release_it) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b0;
            check("release", {a_out_valid, b_out_valid, a_in_ready, b_in_ready}, 4'b0011);
            if (e_code == 2'd0) begin
                exp_a = next_addr(exp_a, WORDS_A);
                exp_b = next_addr(exp_b, WORDS_B);
            end
            check("addr_after_a", a_out_addr, exp_a);
        end else begin
            in_valid = 1'b0;
        end
    endtask

    logic [31:0] gi, gb;
    logic [1:0]  gc;
    logic [31:0] wrap_exp [5];

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        scramble_inputs();
        exp_a = BASE;
        exp_b = BASE;
        repeat (3) @(negedge clk);
        check("rst_ready", {a_in_ready, b_in_ready}, 2'b00);
        check("rst_valid", {a_out_valid, b_out_valid}, 2'b00);
        check("rst_instr", a_out_instr, 32'd0);
        check("rst_addr", a_out_addr, BASE);
        check("rst_err", {a_out_err, a_out_err_code}, 3'd0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", {a_in_ready, b_in_ready}, 2'b11);
        @(negedge clk);

        send(0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 0, 1'b1, gi, gc, gb);
        check("add_const", gi, 32'h002081B3);
        send(1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 0, 1'b1, gi, gc, gb);
        check("addi_const", gi, 32'h00500093);
        send(2, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFC, 0, 1'b1, gi, gc, gb);
        check("sw_const", gi, 32'hFE21AE23);
        send(3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1, 1'b1, gi, gc, gb);
        check("beq_const", gi, 32'h00208463);
        send(4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 0, 1'b1, gi, gc, gb);
        check("lui_const", gi, 32'h123452B7);
        send(5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 0, 1'b1, gi, gc, gb);
        check("jal_const", gi, 32'h001000EF);

        send(1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 0, 1'b1, gi, gc, gb);
        check("range_err", {gc, gi}, {2'd1, 32'h13});
        send(3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 0, 1'b1, gi, gc, gb);
        check("align_err", gc, 2'd2);
        send(7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 0, 1'b1, gi, gc, gb);
        check("fmt_err", gc, 2'd3);
        send(1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 5, 1'b1, gi, gc, gb);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_a = BASE;
        exp_b = BASE;
        wrap_exp = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0};
        for (int n = 0; n < 5; n++) begin
            send(1, 7'h13, 5'(n), 5'd0, 5'd0, 3'd0, 7'd0, 32'(n), 0, 1'b1, gi, gc, gb);
            check("wrap_addr_b", gb, wrap_exp[n]);
        end

        send(0, 7'h33, 5'd7, 5'd8, 5'd9, 3'd0, 7'h20, 32'd0, 2, 1'b0, gi, gc, gb);
        reset = 1'b1;
        @(negedge clk);
        check("rst_hold_valid", {a_out_valid, b_out_valid}, 2'b00);
        check("rst_hold_addr", a_out_addr, BASE);
        check("rst_hold_ready", a_in_ready, 1'b0);
        @(negedge clk);
        check("rst_held_ready", {a_in_ready, b_in_ready}, 2'b00);
        reset = 1'b0;
        exp_a = BASE;
        exp_b = BASE;
        #1;
        check("ready_after_rst2", {a_in_ready, b_in_ready}, 2'b11);
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            int          f;
            logic [31:0] imm;
            f = $urandom_range(0, 7);
            case ($urandom_range(0, 3))
                0: imm = 32'($signed($urandom_range(0, 8191)) - 4096);
                1: imm = $urandom;
                2: imm = $urandom & 32'hFFFF_F000;
                default: imm = 32'($signed($urandom_range(0, 32'h3F_FFFF)) - 32'sh20_0000);
            endcase
            if ((f == 3 || f == 5) && $urandom_range(0, 3) != 0) imm[0] = 1'b0;
            send(f, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                 7'($urandom), imm, $urandom_range(0, 3), 1'b1, gi, gc, gb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
